// File: rtl/btn_bin_counter.sv
// Three debounced push-buttons (inc/dec/clr) driving a WIDTH-bit up/down counter.
// Optional auto-repeat on inc/dec: define BTN_BIN_COUNTER_AUTOREPEAT_EN.

module btn_bin_counter_chan #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic          s_meta;
    logic          s_sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            s_meta <= btn;
            s_sync <= s_meta;
            if (s_sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s_sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

`ifdef BTN_BIN_COUNTER_AUTOREPEAT_EN
module btn_bin_counter_rpt #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic press,
    output logic rpt
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(RPT_MAX + 1);

    logic [TW-1:0] timer;
    logic          periodic;

    // timer counts cycles since the last step; first target is the delay, then the period
    always_comb begin
        rpt = level & ~press &
              (timer == (periodic ? TW'(REPEAT_PERIOD - 1) : TW'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            periodic <= 1'b0;
        end else if (!level || press) begin
            timer    <= '0;
            periodic <= 1'b0;
        end else if (rpt) begin
            timer    <= '0;
            periodic <= 1'b1;
        end else begin
            timer <= timer + 1'b1;
        end
    end
endmodule
`endif

module btn_bin_counter #(
    parameter int WIDTH         = 4,
    parameter int DB_CYCLES     = 65536,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_btn_inc,
    input  logic             i_btn_dec,
    input  logic             i_btn_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wrap
);
    if (WIDTH < 1 || DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_bin_counter: illegal parameter value");
    end

    logic [2:0] lvl;
    logic [2:0] lvl_q;
    logic [2:0] press;
    logic       inc_step;
    logic       dec_step;
    logic       clr_step;

    btn_bin_counter_chan #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clk(clk), .rst_n(rst_n), .btn(i_btn_inc), .level(lvl[0])
    );
    btn_bin_counter_chan #(.DB_CYCLES(DB_CYCLES)) u_dec (
        .clk(clk), .rst_n(rst_n), .btn(i_btn_dec), .level(lvl[1])
    );
    btn_bin_counter_chan #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk(clk), .rst_n(rst_n), .btn(i_btn_clr), .level(lvl[2])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= '0;
        else        lvl_q <= lvl;
    end

    assign press = lvl & ~lvl_q;

`ifdef BTN_BIN_COUNTER_AUTOREPEAT_EN
    logic inc_rpt;
    logic dec_rpt;

    btn_bin_counter_rpt #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc_rpt (
        .clk(clk), .rst_n(rst_n), .level(lvl[0]), .press(press[0]), .rpt(inc_rpt)
    );
    btn_bin_counter_rpt #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec_rpt (
        .clk(clk), .rst_n(rst_n), .level(lvl[1]), .press(press[1]), .rpt(dec_rpt)
    );

    assign inc_step = press[0] | inc_rpt;
    assign dec_step = press[1] | dec_rpt;
`else
    assign inc_step = press[0];
    assign dec_step = press[1];
`endif
    assign clr_step = press[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
            o_wrap <= 1'b0;
        end else if (clr_step) begin
            o_data <= '0;
            o_wrap <= 1'b0;
        end else if (inc_step && dec_step) begin
            o_wrap <= 1'b0;
        end else if (inc_step) begin
            o_data <= o_data + 1'b1;
            o_wrap <= &o_data;
        end else if (dec_step) begin
            o_data <= o_data - 1'b1;
            o_wrap <= (o_data == '0);
        end else begin
            o_wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_btn_bin_counter.sv
// Randomised and directed checks of btn_bin_counter against a cycle-level reference model.
module tb_btn_bin_counter;
    localparam int WIDTH = 4;
    localparam int DB    = 8;
    localparam int RD    = 32;
    localparam int RP    = 8;
    localparam int MODV  = 2 ** WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             b_inc = 1'b0;
    logic             b_dec = 1'b0;
    logic             b_clr = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic             o_wrap;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_bin_counter #(
        .WIDTH(WIDTH), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn_inc(b_inc), .i_btn_dec(b_dec),
        .i_btn_clr(b_clr), .o_data(o_data), .o_wrap(o_wrap)
    );

    // Reference: raw input seen 2 edges late; level flips after DB consecutive differing
    // samples; a step lands one edge after the level rises; repeats timed by edge number.
    int m_data;
    bit m_wrap;
    bit ms1 [3];
    bit ms2 [3];
    bit md  [3];
    bit mdq [3];
    int run [3];
    int press_at [3];
    int m_edge;

    always @(posedge clk or negedge rst_n) begin : model
        bit ev  [3];
        bit raw [3];
        int el;
        if (!rst_n) begin
            m_data = 0;
            m_wrap = 0;
            m_edge = 0;
            for (int c = 0; c < 3; c++) begin
                ms1[c] = 0; ms2[c] = 0; md[c] = 0; mdq[c] = 0; run[c] = 0; press_at[c] = 0;
            end
        end else begin
            raw[0] = b_inc; raw[1] = b_dec; raw[2] = b_clr;
            for (int c = 0; c < 3; c++) begin
                ev[c] = md[c] && !mdq[c];
                if (ev[c]) press_at[c] = m_edge;
`ifdef BTN_BIN_COUNTER_AUTOREPEAT_EN
                if (c < 2 && md[c] && mdq[c]) begin
                    el = m_edge - press_at[c];
                    if (el == RD || (el > RD && (el - RD) % RP == 0)) ev[c] = 1;
                end
`endif
            end
            if (ev[2]) begin
                m_data = 0; m_wrap = 0;
            end else if (ev[0] && ev[1]) begin
                m_wrap = 0;
            end else if (ev[0]) begin
                m_wrap = (m_data == MODV - 1); m_data = (m_data + 1) % MODV;
            end else if (ev[1]) begin
                m_wrap = (m_data == 0); m_data = (m_data + MODV - 1) % MODV;
            end else begin
                m_wrap = 0;
            end
            for (int c = 0; c < 3; c++) begin
                mdq[c] = md[c];
                if (ms2[c] != md[c]) begin
                    run[c]++;
                    if (run[c] == DB) begin md[c] = ms2[c]; run[c] = 0; end
                end else begin
                    run[c] = 0;
                end
                ms2[c] = ms1[c];
                ms1[c] = raw[c];
            end
            m_edge++;
        end
    end

    task automatic drive(input bit i, input bit d, input bit c);
        @(negedge clk);
        b_inc = i; b_dec = d; b_clr = c;
    endtask

    task automatic test_reset;
        b_inc = 1; b_dec = 0; b_clr = 0; rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== '0 || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: o_data=%0d o_wrap=%0b, need 0/0", o_data, o_wrap);
            end
        end
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'((k >= DB + 2) ? 1 : 0) || o_wrap !== 1'b0
                || o_data !== WIDTH'(m_data)) begin
                n_err++;
                $display("FAIL reset_release edge %0d: o_data=%0d o_wrap=%0b, need %0d/0",
                         k, o_data, o_wrap, (k >= DB + 2) ? 1 : 0);
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
    endtask

    task automatic test_single_press;
        int base;
        base = m_data;
        drive(1, 0, 0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'((k >= DB + 2) ? base + 1 : base) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL single_press edge %0d: o_data=%0d o_wrap=%0b, need %0d/0",
                         k, o_data, o_wrap, (k >= DB + 2) ? base + 1 : base);
            end
        end
        drive(0, 0, 0);
        for (int k = 0; k < 2 * DB + 4; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'(base + 1) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL single_release: o_data=%0d o_wrap=%0b, need %0d/0",
                         o_data, o_wrap, base + 1);
            end
        end
    endtask

    task automatic test_bounce;
        int base;
        base = m_data;
        for (int t = 0; t < 10; t++) begin
            drive(t % 2 == 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                n_vec++;
                if (o_data !== WIDTH'(base) || o_wrap !== 1'b0) begin
                    n_err++;
                    $display("FAIL bounce: o_data=%0d o_wrap=%0b, need %0d/0", o_data, o_wrap, base);
                end
            end
        end
        drive(1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'((k >= DB + 2) ? base + 1 : base) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_settle edge %0d: o_data=%0d, need %0d",
                         k, o_data, (k >= DB + 2) ? base + 1 : base);
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
    endtask

    task automatic test_wrap;
        int wraps;
        drive(0, 0, 1);
        repeat (DB + 4) @(posedge clk);
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
        wraps = 0;
        for (int p = 0; p < MODV; p++) begin
            drive(1, 0, 0);
            repeat (DB + 4) begin
                @(posedge clk); #1;
                if (o_wrap === 1'b1) wraps++;
                n_vec++;
                if (o_data !== WIDTH'(m_data) || o_wrap !== m_wrap) begin
                    n_err++;
                    $display("FAIL wrap_inc: o_data=%0d o_wrap=%0b, need %0d/%0b",
                             o_data, o_wrap, m_data, m_wrap);
                end
            end
            drive(0, 0, 0);
            repeat (DB + 4) @(posedge clk);
            #1;
            n_vec++;
            if (o_data !== WIDTH'((p + 1) % MODV)) begin
                n_err++;
                $display("FAIL wrap_count press %0d: o_data=%0d, need %0d", p, o_data, (p + 1) % MODV);
            end
        end
        n_vec++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL wrap_inc_pulses: saw %0d, need 1", wraps);
        end
        wraps = 0;
        drive(0, 1, 0);
        repeat (DB + 4) begin
            @(posedge clk); #1;
            if (o_wrap === 1'b1) wraps++;
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
        #1;
        n_vec++;
        if (o_data !== WIDTH'(MODV - 1) || wraps != 1) begin
            n_err++;
            $display("FAIL wrap_dec: o_data=%0d pulses=%0d, need %0d/1", o_data, wraps, MODV - 1);
        end
    endtask

    task automatic test_simultaneous;
        drive(0, 0, 1);
        repeat (DB + 4) @(posedge clk);
        for (int p = 0; p < 5; p++) begin
            drive(1, 0, 0);
            repeat (DB + 4) @(posedge clk);
            drive(0, 0, 0);
            repeat (DB + 4) @(posedge clk);
        end
        drive(1, 1, 0);
        for (int k = 0; k < DB + 4; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'(5) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL inc_dec_same: o_data=%0d o_wrap=%0b, need 5/0", o_data, o_wrap);
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
        drive(1, 0, 1);
        for (int k = 0; k < DB + 4; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'((k >= DB + 2) ? 0 : 5) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL clr_inc_same edge %0d: o_data=%0d o_wrap=%0b, need %0d/0",
                         k, o_data, o_wrap, (k >= DB + 2) ? 0 : 5);
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
    endtask

    task automatic test_autorepeat;
        int want;
        drive(0, 0, 1);
        repeat (DB + 4) @(posedge clk);
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
        drive(1, 0, 0);
        for (int k = 0; k < 80; k++) begin
            if (k == 60) begin
                #4;
                b_inc = 0;
            end
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'(m_data) || o_wrap !== m_wrap) begin
                n_err++;
                $display("FAIL autorepeat edge %0d: o_data=%0d o_wrap=%0b, need %0d/%0b",
                         k, o_data, o_wrap, m_data, m_wrap);
            end
        end
`ifdef BTN_BIN_COUNTER_AUTOREPEAT_EN
        want = 5;
`else
        want = 1;
`endif
        n_vec++;
        if (o_data !== WIDTH'(want)) begin
            n_err++;
            $display("FAIL autorepeat_final: o_data=%0d, need %0d", o_data, want);
        end
    endtask

    task automatic test_random;
        int hold;
        for (int s = 0; s < 60; s++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 2 * DB + 6);
            repeat (hold) begin
                @(posedge clk); #1;
                n_vec++;
                if (o_data !== WIDTH'(m_data) || o_wrap !== m_wrap) begin
                    n_err++;
                    $display("FAIL random seg %0d: o_data=%0d o_wrap=%0b, need %0d/%0b",
                             s, o_data, o_wrap, m_data, m_wrap);
                end
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== '0 || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_hold: o_data=%0d o_wrap=%0b, need 0/0", o_data, o_wrap);
            end
        end
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (o_data !== WIDTH'((k >= DB + 2) ? 1 : 0) || o_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_release edge %0d: o_data=%0d, need %0d",
                         k, o_data, (k >= DB + 2) ? 1 : 0);
            end
        end
        drive(0, 0, 0);
        repeat (DB + 4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_wrap();
        test_simultaneous();
        test_autorepeat();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btn_bin_counter.md
Name: btn_bin_counter

Overview:
- Upstream data source for the 4-digit binary scan display.
- Takes three raw push-buttons (increment, decrement, clear) from board pins.
- Each button is synchronised and debounced; the block keeps a WIDTH-bit up/down counter.
- Counter value is presented as o_data, which drives the display's 4-bit data input directly.

Parameters:
- WIDTH, 4, counter/output width in bits; must be at least 1.
- DB_CYCLES, 65536, cycles a synchronised input must differ from its debounced level before that level flips; must be at least 2.
- REPEAT_DELAY, 25000000, cycles from a press step to the first auto-repeat step. Used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps. Used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_btn_inc  input  1  raw increment button, active-high, asynchronous, may bounce
- i_btn_dec  input  1  raw decrement button, same properties
- i_btn_clr  input  1  raw clear button, same properties
- o_data  output  WIDTH  current counter value
- o_wrap  output  1  one-cycle pulse when a step wraps the counter

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset clears every flop: synchronisers, debounced levels, debounce counters, previous-level registers, o_data=0, o_wrap=0. Reset asserted mid-debounce or mid-hold aborts everything; after release, a button still held must be debounced again from zero.
- Per button, identical channel:
  - Two-flop synchroniser produces s.
  - Debounced level d, reset 0.
  - Debounce counter of width clog2(DB_CYCLES). It is cleared on any cycle where s==d. It increments on any cycle where s!=d.
  - When s!=d and the counter equals DB_CYCLES-1, d<=s and the counter clears.
  - A glitch or bounce shorter than DB_CYCLES cycles never changes d.
- Press event: combinational d & ~d_q, where d_q is d delayed one cycle. Exactly one event per debounced rising edge.
- Timing: raw input goes high before edge 0 and stays stable. The synchroniser samples it at edge 0, d rises at edge DB_CYCLES+1, and o_data changes at edge DB_CYCLES+2. Release is symmetric and produces no step.
- Counter update each cycle, in priority order:
  - clr event: o_data<=0, o_wrap<=0. This applies regardless of inc/dec events in the same cycle.
  - inc and dec events in the same cycle: no change, o_wrap<=0.
  - inc only: o_data<=o_data+1 modulo 2^WIDTH. o_wrap<=1 iff o_data was all ones.
  - dec only: o_data<=o_data-1 modulo 2^WIDTH. o_wrap<=1 iff o_data was 0.
  - No event: hold o_data, o_wrap<=0.
- o_wrap is registered and asserts in the same cycle o_data shows the wrapped value. It is high for exactly one cycle per wrapping step.
- Holding a button with no repeat feature gives one step only. Other buttons remain fully independent while one is held.

Optional Feature:
- Macro: BTN_BIN_COUNTER_AUTOREPEAT_EN.
- Defined:
  - inc and dec channels each get a repeat timer, cleared on the press event.
  - While d stays high, the channel emits an extra step event REPEAT_DELAY cycles after the press step, then every REPEAT_PERIOD cycles.
  - Repeat events follow the same priority and wrap rules as press events.
  - The timer stops and clears when d falls.
  - clr never repeats.
- Undefined:
  - No repeat timers are instantiated; REPEAT_* parameters are ignored.
  - Exactly one step per debounced press.

Test Plan:
- Reset: assert rst_n=0 for 3 cycles with buttons pressed, then release -> o_data=0 and o_wrap=0 throughout reset. Buttons held across reset step once, only after DB_CYCLES+2 further edges.
- DB_CYCLES=8, i_btn_inc high edges 0..29 then low -> o_data 0->1 at edge 10 and stays 1 after release; o_wrap stays 0.
- DB_CYCLES=8, i_btn_inc toggled every 3 cycles for 30 cycles, then stable high -> exactly one increment, occurring 10 edges after the last toggle.
- 16 inc presses from 0 -> o_data 1..15 then 0, with one o_wrap pulse on the 0; then one dec press -> o_data=15 with one o_wrap pulse.
- inc and dec debounced in the same cycle with o_data=5 -> o_data stays 5. Then clr and inc in the same cycle with o_data=5 -> o_data=0, o_wrap=0.
- BTN_BIN_COUNTER_AUTOREPEAT_EN, DB_CYCLES=8, REPEAT_DELAY=32, REPEAT_PERIOD=8, inc raw high edges 0..59 -> steps at edges 10, 42, 50, 58, 66, final o_data=5. Without the macro, same stimulus -> o_data=1.
